// File: rtl/shared_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_arbiter_pkg
// Description : Owner encoding and requester indices shared by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package shared_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'b00,
        OWNER_CPU  = 2'b01,
        OWNER_DMA  = 2'b10
    } owner_e;

    localparam int c_REQ_CPU = 0;
    localparam int c_REQ_DMA = 1;
    localparam int c_NUM_REQ = 2;

endpackage : shared_mem_arbiter_pkg
`default_nettype wire

// File: rtl/shared_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_arbiter_if
// Description : CPU, DMA and memory-side signals of the shared memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface shared_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_adr;
    logic [DATA_WIDTH-1:0] cpu_wd;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_adr;
    logic [DATA_WIDTH-1:0] dma_wd;
    logic                  dma_lock;
    logic                  dma_gnt;
    logic                  dma_rvalid;
    logic [DATA_WIDTH-1:0] dma_rdata;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    // Arbiter side: sees requests and memory read data, drives grants and memory
    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wd,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_adr, dma_wd, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wd,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_adr, dma_wd, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );
endinterface : shared_mem_arbiter_if
`default_nettype wire

// File: rtl/shared_mem_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module      : arb_grant_logic
// Description : Combinational round-robin grant with hold limit and DMA lock.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_grant_logic
    import shared_mem_arbiter_pkg::*;
#(
    parameter int MAX_HOLD  = 4,
    parameter int CPU_FIRST = 1,
    parameter int HOLD_W    = $clog2(MAX_HOLD + 1)
) (
    input  wire owner_e              i_owner,
    input  wire logic [HOLD_W-1:0]   i_hold_cnt,
    input  wire logic                i_lock_q,
    input  wire logic [c_NUM_REQ-1:0] i_reqs,
    input  wire logic                i_reset_n,
    output logic                     o_cpu_gnt,
    output logic                     o_dma_gnt
);
    localparam logic [HOLD_W-1:0] c_MAX_HOLD = HOLD_W'(MAX_HOLD);
    localparam logic              c_CPU_WINS = (CPU_FIRST != 0);

    logic w_cpu_req;
    logic w_dma_req;

    assign w_cpu_req = i_reqs[c_REQ_CPU];
    assign w_dma_req = i_reqs[c_REQ_DMA];

    always_comb begin
        o_cpu_gnt = 1'b0;
        o_dma_gnt = 1'b0;
        if (i_reset_n) begin
            if (i_lock_q && w_dma_req) begin
                o_dma_gnt = 1'b1;
            end else if (w_cpu_req && !w_dma_req) begin
                o_cpu_gnt = 1'b1;
            end else if (w_dma_req && !w_cpu_req) begin
                o_dma_gnt = 1'b1;
            end else if (w_cpu_req && w_dma_req) begin
                // Contention: current owner keeps the memory until its hold budget runs out
                case (i_owner)
                    OWNER_CPU: begin
                        o_cpu_gnt = (i_hold_cnt < c_MAX_HOLD);
                        o_dma_gnt = !(i_hold_cnt < c_MAX_HOLD);
                    end
                    OWNER_DMA: begin
                        o_dma_gnt = (i_hold_cnt < c_MAX_HOLD);
                        o_cpu_gnt = !(i_hold_cnt < c_MAX_HOLD);
                    end
                    default: begin
                        o_cpu_gnt = c_CPU_WINS;
                        o_dma_gnt = !c_CPU_WINS;
                    end
                endcase
            end
        end
    end
endmodule : arb_grant_logic
`default_nettype wire

// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_arbiter
// Description : Shares one memory between CPU and DMA; registered read return.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 4,
    parameter int CPU_FIRST  = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    shared_mem_arbiter_if.slave bus
);
    localparam int                  c_HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_MAX_HOLD = c_HOLD_W'(MAX_HOLD);
    localparam logic [c_HOLD_W-1:0] c_ONE      = c_HOLD_W'(1);

    owner_e                r_owner;
    owner_e                w_owner_nxt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_HOLD_W-1:0]   w_hold_nxt;
    logic [c_HOLD_W-1:0]   w_hold_inc;
    logic                  r_lock_q;
    logic                  w_lock_nxt;
    logic [c_NUM_REQ-1:0]  w_reqs;
    logic                  w_cpu_gnt;
    logic                  w_dma_gnt;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_a;
    logic [DATA_WIDTH-1:0] w_mem_wd;
    logic                  r_cpu_rvalid;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic                  r_dma_rvalid;
    logic [DATA_WIDTH-1:0] r_dma_rdata;

    assign w_reqs[c_REQ_CPU] = bus.cpu_req;
    assign w_reqs[c_REQ_DMA] = bus.dma_req;

    arb_grant_logic #(
        .MAX_HOLD  (MAX_HOLD),
        .CPU_FIRST (CPU_FIRST),
        .HOLD_W    (c_HOLD_W)
    ) u_grant (
        .i_owner    (r_owner),
        .i_hold_cnt (r_hold_cnt),
        .i_lock_q   (r_lock_q),
        .i_reqs     (w_reqs),
        .i_reset_n  (reset),
        .o_cpu_gnt  (w_cpu_gnt),
        .o_dma_gnt  (w_dma_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner    <= OWNER_IDLE;
            r_hold_cnt <= '0;
            r_lock_q   <= 1'b0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_lock_q   <= w_lock_nxt;
        end
    end

    // Hold count saturates so a long uncontested run still yields at the next contention
    assign w_hold_inc = (r_hold_cnt < c_MAX_HOLD) ? r_hold_cnt + c_ONE : r_hold_cnt;

    always_comb begin
        w_owner_nxt = OWNER_IDLE;
        w_hold_nxt  = '0;
        w_lock_nxt  = w_dma_gnt & bus.dma_lock;
        if (w_cpu_gnt) begin
            w_owner_nxt = OWNER_CPU;
            w_hold_nxt  = (r_owner == OWNER_CPU) ? w_hold_inc : c_ONE;
        end else if (w_dma_gnt) begin
            w_owner_nxt = OWNER_DMA;
            w_hold_nxt  = (r_owner == OWNER_DMA) ? w_hold_inc : c_ONE;
        end
    end

    always_comb begin
        w_mem_we = 1'b0;
        w_mem_a  = {ADDR_WIDTH{1'b0}};
        w_mem_wd = {DATA_WIDTH{1'b0}};
        if (w_cpu_gnt) begin
            w_mem_we = bus.cpu_we;
            w_mem_a  = bus.cpu_adr;
            w_mem_wd = bus.cpu_wd;
        end else if (w_dma_gnt) begin
            w_mem_we = bus.dma_we;
            w_mem_a  = bus.dma_adr;
            w_mem_wd = bus.dma_wd;
        end
    end

    // Read data is captured only on granted reads and otherwise held for the requester
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~bus.cpu_we;
            r_dma_rvalid <= w_dma_gnt & ~bus.dma_we;
            if (w_cpu_gnt && !bus.cpu_we) begin
                r_cpu_rdata <= bus.mem_rd;
            end
            if (w_dma_gnt && !bus.dma_we) begin
                r_dma_rdata <= bus.mem_rd;
            end
        end
    end

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.dma_gnt    = w_dma_gnt;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_a      = w_mem_a;
    assign bus.mem_wd     = w_mem_wd;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.dma_rvalid = r_dma_rvalid;
    assign bus.dma_rdata  = r_dma_rdata;
endmodule : shared_mem_arbiter
`default_nettype wire

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Arbitrates the single shared instruction/data memory between two requesters: the multicycle ARM core and a DMA/debug loader port.
- Sits between the requesters and the memory (`mem`): memory reads are combinational, writes are synchronous.
- Grants at most one access per cycle, using round-robin with a bounded hold count.
- The DMA can lock the memory for bursts.
- Read data is registered and returned one cycle after the grant.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MAX_HOLD, 4, max consecutive grants to one requester while the other is requesting (must be >= 1).
- CPU_FIRST, 1, tie-break from IDLE: 1 = CPU wins, 0 = DMA wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, this cycle.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_adr  in  ADDR_WIDTH  CPU byte address.
- cpu_wd  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_rvalid  out  1  CPU read data valid (one cycle).
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- dma_req  in  1  DMA access request.
- dma_we  in  1  DMA write/read.
- dma_adr  in  ADDR_WIDTH  DMA byte address.
- dma_wd  in  DATA_WIDTH  DMA write data.
- dma_lock  in  1  keep DMA ownership for the next beat.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  DATA_WIDTH  DMA read data.
- mem_we  out  1  memory write enable.
- mem_a  out  ADDR_WIDTH  memory address.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  memory combinational read data.

Behaviour:
- Reset (reset=0, async):
  - owner=IDLE, hold_cnt=0, lock_q=0.
  - Both rvalid=0, both rdata=0.
  - cpu_gnt=dma_gnt=0 combinationally while reset=0; mem_we=0.
- State: `owner` register with states IDLE, CPU, DMA. It records the requester granted in the previous cycle.
- Grant is combinational and same-cycle; the access completes in the granted cycle (write at the rising edge). Requesters hold req/adr/we/wd stable until they see gnt.
- Grant rules, evaluated in priority order:
  - lock_q=1 and dma_req: DMA.
  - One requester only: that one.
  - Both requesting, owner=IDLE: CPU if CPU_FIRST, else DMA.
  - Both requesting, owner=CPU: CPU if hold_cnt<MAX_HOLD, else DMA. Symmetric for owner=DMA.
  - Neither requesting: no grant.
- Next state:
  - Grant this cycle: owner<=granted. hold_cnt<=hold_cnt+1 if same owner as before (saturating at MAX_HOLD), else 1.
  - No grant: owner<=IDLE, hold_cnt<=0.
- Lock:
  - lock_q<=dma_gnt & dma_lock.
  - Lock overrides the hold limit and CPU_FIRST.
  - Lock lapses if dma_req=0 in the locked cycle; CPU is then eligible in that same cycle.
- Memory mux:
  - Granted requester drives mem_a/mem_wd, and mem_we=req_we.
  - No grant: mem_we=0, mem_a=0, mem_wd=0.
- Read return:
  - On a granted read, rdata<=mem_rd and rvalid<=1 at the clock edge; rvalid lasts one cycle.
  - rdata holds its value until the next read for that requester.
  - Writes never raise rvalid.
- Latency: grant 0 cycles; read data 1 cycle. Throughput: 1 access per cycle.
- Simultaneous: never both gnt=1 in the same cycle (invariant).
- Reset mid-operation: pending rvalid is cleared; a read granted in the reset cycle returns nothing; lock is dropped.
- hold_cnt width: $clog2(MAX_HOLD+1).

Decomposition:
- Shared package:
  - owner encoding: IDLE=2'b00, CPU=2'b01, DMA=2'b10.
  - requester index constants.
- Sub-module arb_grant_logic (combinational):
  - Inputs: owner, hold_cnt, lock_q, reqs, reset.
  - Outputs: cpu_gnt, dma_gnt.
- Top block holds the state registers, the memory mux, and the two read-return registers (flopenr-style).

Test Plan:
- Reset: drive reset=0 with cpu_req=dma_req=1. Expect cpu_gnt=dma_gnt=0, mem_we=0, rvalid=0, rdata=0. Release reset: CPU is granted first (CPU_FIRST=1).
- CPU read: cpu_req=1, cpu_we=0, cpu_adr=0x10, memory word 0xE04F000F. Expect cpu_gnt=1 and mem_a=0x10 in the same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xE04F000F; the cycle after, cpu_rvalid=0.
- Fairness: both requesting continuously from IDLE, MAX_HOLD=4. Grants follow C,C,C,C,D,D,D,D,C,... and both gnt are never high together.
- Lock burst: DMA writes 0x100..0x114 (6 beats) with dma_lock=1 on beats 1-5 and 0 on beat 6, while cpu_req=1 throughout. Expect 6 consecutive dma_gnt, cpu_gnt=0, then cpu_gnt=1 on the following cycle.
- Write-then-read: DMA writes 0xDEADBEEF to 0x20, then CPU reads 0x20. Expect cpu_rdata=0xDEADBEEF one cycle after cpu_gnt, and dma_rvalid never asserts.
- Reset mid-read: assert reset during a granted DMA read. Expect dma_rvalid=0 afterwards, owner=IDLE, and lock cleared.
